// File: rtl/uart_cmd_assembler.sv
// Assembles fixed-length UART byte frames (first byte = MSB) into one command word.
// Define CHECKSUM_EN to require a trailing checksum byte per frame (payload sum + C == 8'hFF).
module uart_cmd_assembler #(
  parameter int NUM_BYTES      = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_rdy,
  output logic                   clr_rx_rdy,
  output logic [8*NUM_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  output logic                   overrun,
  output logic                   timeout,
  output logic                   chk_err
);

`ifdef CHECKSUM_EN
  localparam int FRAME_LEN = NUM_BYTES + 1;
`else
  localparam int FRAME_LEN = NUM_BYTES;
`endif
  localparam int CMD_W = 8 * NUM_BYTES;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_PAYLOAD = CNT_W'(NUM_BYTES);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   count, count_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic [CMD_W-1:0]   shadow, shadow_n;
  logic [CMD_W-1:0]   cmd_n;
  logic               cmd_rdy_n, overrun_n, timeout_n;
  logic               frame_done, frame_good;
`ifdef CHECKSUM_EN
  logic [7:0]         sum, sum_n, sum_chk;
  logic               chk_err_n;
`endif

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] t);
    return (t == {TMR_W{1'b1}}) ? t : t + 1'b1;
  endfunction

  function automatic logic [CMD_W-1:0] shift_in(input logic [CMD_W-1:0] s,
                                                input logic [7:0] b);
    return {s[CMD_W-9:0], b};
  endfunction

  // Every presented byte is taken immediately, so the receiver is cleared combinationally.
  assign clr_rx_rdy = rx_rdy;

  always_comb begin
    state_n    = state;
    count_n    = count;
    timer_n    = timer;
    shadow_n   = shadow;
    cmd_n      = cmd;
    cmd_rdy_n  = cmd_rdy;
    overrun_n  = overrun;
    timeout_n  = 1'b0;
    frame_done = 1'b0;
    frame_good = 1'b1;
`ifdef CHECKSUM_EN
    sum_n      = sum;
    sum_chk    = sum + rx_data;
    chk_err_n  = 1'b0;
`endif

    if (cmd_rdy && clr_cmd_rdy) cmd_rdy_n = 1'b0;

    case (state)
      IDLE: begin
        if (rx_rdy) begin
          shadow_n = shift_in(shadow, rx_data);
          count_n  = CNT_W'(1);
          timer_n  = '0;
          state_n  = COLLECT;
`ifdef CHECKSUM_EN
          sum_n    = rx_data;
`endif
        end
      end
      COLLECT: begin
        if (rx_rdy) begin
          timer_n = '0;
          count_n = count + 1'b1;
          if (count < CNT_PAYLOAD) begin
            shadow_n = shift_in(shadow, rx_data);
`ifdef CHECKSUM_EN
            sum_n    = sum_chk;
`endif
          end
          if (count == CNT_LAST) begin
            frame_done = 1'b1;
            state_n    = IDLE;
            count_n    = '0;
`ifdef CHECKSUM_EN
            frame_good = (sum_chk == 8'hFF);
`endif
          end
        end else if (timer == TMR_LAST) begin
          // Stale partial frame: drop it but leave any delivered command alone.
          timeout_n = 1'b1;
          state_n   = IDLE;
          count_n   = '0;
          timer_n   = '0;
          shadow_n  = '0;
        end else begin
          timer_n = sat_inc(timer);
        end
      end
      default: state_n = IDLE;
    endcase

    if (frame_done) begin
      if (!frame_good) begin
`ifdef CHECKSUM_EN
        chk_err_n = 1'b1;
`endif
      end else if (!cmd_rdy || clr_cmd_rdy) begin
        cmd_n     = shadow_n;
        cmd_rdy_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      timer   <= '0;
      shadow  <= '0;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      timer   <= timer_n;
      shadow  <= shadow_n;
      cmd     <= cmd_n;
      cmd_rdy <= cmd_rdy_n;
      overrun <= overrun_n;
      timeout <= timeout_n;
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sum     <= '0;
      chk_err <= 1'b0;
    end else begin
      sum     <= sum_n;
      chk_err <= chk_err_n;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule
